instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001: Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004: imem_req_valid  output  1  fetch request to instruction memory.
REQ-005: imem_req_ready  input  1  memory accepts request when high with imem_req_valid.
REQ-006: imem_req_addr  output  16  byte address of requested word.
REQ-007: imem_resp_valid  input  1  one 32-bit response word present this cycle.
REQ-008: imem_resp_data  input  32  instruction word.
REQ-009: redirect_valid  input  1  branch/jump redirect from execute stage.
REQ-010: redirect_pc  input  16  redirect target address.
REQ-011: instr_valid  output  1  instruction presented to decode/ALU stage.
REQ-012: instr_ready  input  1  downstream accepts instruction when high with instr_valid.
REQ-013: instr_code  output  32  instruction word, opcode in bits [6:0].
REQ-014: instr_pc  output  16  address of instr_code.
REQ-015: fetch_fault  output  1  misaligned redirect fault flag.

Function
REQ-016: Block SHALL hold fetch PC, 2-entry instruction FIFO (code+pc), outstanding-request counter (0..2), stale-response counter (0..2).
REQ-017: Memory SHALL return responses in order, one per accepted request, latency >=1 cycle; block accepts imem_resp_valid without backpressure.
REQ-018: imem_req_valid SHALL be high only when state is FETCH, redirect_valid is low, and outstanding + FIFO occupancy < 2.
REQ-019: imem_req_addr SHALL equal fetch PC; on request handshake PC increments by 4, wrapping 16'hFFFC -> 16'h0000.
REQ-020: Non-stale response SHALL be written to FIFO tail with pc of its request; outstanding decrements.
REQ-021: instr_valid SHALL equal FIFO not-empty AND redirect_valid low; instr_code/instr_pc driven from FIFO head; pop on instr_valid && instr_ready.
REQ-022: Simultaneous push and pop SHALL keep occupancy unchanged; push to full FIFO cannot occur by REQ-018.
REQ-023: On redirect_valid (edge): FIFO emptied, PC <= redirect_pc, stale counter <= outstanding count after this cycle's request/response updates, outstanding <= 0.
REQ-024: While stale counter > 0, each response SHALL be discarded and decrement stale counter; no new request issued until stale counter = 0.
REQ-025: Response arriving in redirect cycle SHALL be discarded and not counted as stale.
REQ-026: States: FETCH (normal), FAULT (halted); FAULT reachable only per REQ-031; FAULT exits only via reset.
REQ-027: Fetch-to-instr_valid latency SHALL be memory latency + 1 cycle (response registered into FIFO).

Reset
REQ-028: On rst_n low: PC = RESET_PC, FIFO empty, counters 0, state FETCH, fetch_fault 0.
REQ-029: Outputs during reset: imem_req_valid 0, instr_valid 0, instr_code 0, instr_pc 0.
REQ-030: Reset mid-transaction SHALL abandon outstanding requests; memory is reset by same rst_n.

Configuration
REQ-031: With FETCH_ALIGN_CHECK_EN defined, redirect_pc[1:0] != 0 SHALL set fetch_fault=1, enter FAULT, flush FIFO, stop requests; fault sticky until reset.
REQ-032: Without FETCH_ALIGN_CHECK_EN, redirect_pc[1:0] SHALL be forced to 2'b00, fetch_fault tied 0, FAULT unused.

Verification
REQ-033: Reset, ready=1, 1-cycle memory, instr_ready=1 -> requests 0x0000,0x0004,0x0008; instr_pc same order, codes match memory.
REQ-034: instr_ready=0 for 10 cycles -> FIFO fills to 2, exactly 2 requests issued, no further requests until pop.
REQ-035: Two outstanding requests, redirect_pc=0x0100 -> both responses dropped, next instr_pc=0x0100, no instr from old stream.
REQ-036: PC at 0xFFFC -> next request address 0x0000.
REQ-037: FETCH_ALIGN_CHECK_EN, redirect_pc=0x0102 -> fetch_fault=1 next cycle, imem_req_valid=0, instr_valid=0 until reset; without macro -> fetch from 0x0100.
REQ-038: rst_n low with 2 outstanding -> all outputs at REQ-029 values; after release first request 0x0000.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: in-order instruction fetch with a 2-entry instruction buffer and redirect flush.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned redirect target halts fetch with a sticky fault.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [15:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_code,
  output logic [15:0] instr_pc,
  output logic        fetch_fault
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;

  logic [15:0] pc_r;
  logic        run_r;
  logic [31:0] fifo_code_r [2];
  logic [15:0] fifo_pc_r   [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;
  logic [1:0]  outst_r;
  logic [1:0]  stale_r;

  logic [15:0] target_s;
  logic        misaligned_s;
  logic        redirect_s;
  logic        req_fire_s;
  logic        resp_live_s;
  logic        resp_stale_s;
  logic        push_s;
  logic        pop_s;
  logic [1:0]  outst_after_s;
  logic [1:0]  stale_after_s;
  logic [2:0]  occupancy_s;
  logic [15:0] resp_pc_s;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned_s = (redirect_pc[1:0] != 2'b00);
  assign target_s     = redirect_pc;
  assign fetch_fault  = (state_r == S_FAULT);
`else
  logic unused_align_s;
  assign misaligned_s   = 1'b0;
  assign target_s       = {redirect_pc[15:2], 2'b00};
  assign fetch_fault    = 1'b0;
  assign unused_align_s = ^redirect_pc[1:0];
`endif

  assign redirect_s    = redirect_valid & (state_r == S_FETCH);
  assign req_fire_s    = imem_req_valid & imem_req_ready;
  assign resp_stale_s  = imem_resp_valid & (stale_r != 2'd0);
  assign resp_live_s   = imem_resp_valid & (stale_r == 2'd0);
  assign push_s        = resp_live_s & ~redirect_valid & (state_r == S_FETCH);
  assign pop_s         = instr_valid & instr_ready;
  assign occupancy_s   = {1'b0, outst_r} + {1'b0, count_r};
  assign outst_after_s = outst_r + {1'b0, req_fire_s} - {1'b0, resp_live_s};
  assign stale_after_s = stale_r - {1'b0, resp_stale_s};
  // Live requests are sequential, so the oldest one sits outst_r words behind the fetch PC.
  assign resp_pc_s     = pc_r - {12'd0, outst_r, 2'b00};

  assign imem_req_addr = pc_r;
  assign instr_code    = fifo_code_r[rd_ptr_r];
  assign instr_pc      = fifo_pc_r[rd_ptr_r];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; FAULT is left only through reset
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (redirect_valid && misaligned_s) begin
          state_nx_s = S_FAULT;
        end else begin
          state_nx_s = S_FETCH;
        end
      end
      S_FAULT: state_nx_s = S_FAULT;
      default: state_nx_s = S_FETCH;
    endcase
  end

  // Handshake outputs; a pop does not free a request slot in the same cycle
  always_comb begin
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req_valid = run_r & ~redirect_valid & (stale_r == 2'd0) & (occupancy_s < 3'd2);
        instr_valid    = (count_r != 2'd0) & ~redirect_valid;
      end
      S_FAULT: begin
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
      end
      default: begin
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
      end
    endcase
  end

  // Fetch PC and post-reset request enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r  <= RESET_PC;
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (redirect_s) begin
        pc_r <= target_s;
      end else if (req_fire_s) begin
        pc_r <= pc_r + 16'd4;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  // In-flight tracking; on redirect every still-pending response becomes stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_r <= 2'd0;
      stale_r <= 2'd0;
    end else if (redirect_valid) begin
      outst_r <= 2'd0;
      stale_r <= stale_after_s + outst_after_s;
    end else begin
      outst_r <= outst_after_s;
      stale_r <= stale_after_s;
    end
  end

  // Two-entry instruction buffer, flushed on redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r       <= 1'b0;
      wr_ptr_r       <= 1'b0;
      count_r        <= 2'd0;
      fifo_code_r[0] <= 32'd0;
      fifo_code_r[1] <= 32'd0;
      fifo_pc_r[0]   <= 16'd0;
      fifo_pc_r[1]   <= 16'd0;
    end else if (redirect_valid) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_code_r[wr_ptr_r] <= imem_resp_data;
        fifo_pc_r[wr_ptr_r]   <= resp_pc_s;
        wr_ptr_r              <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: in-order memory model, sequential-stream scoreboard, directed scenarios.
module tb_instr_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_code;
  logic [15:0] instr_pc;
  logic        fetch_fault;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_code      (instr_code),
    .instr_pc        (instr_pc),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  int          cyc = 0;
  int          lat = 1;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [31:0] req_log[$];
  logic [31:0] ipc_log[$];
  logic [31:0] icode_log[$];
  int          first_req = -1;
  int          first_ins = -1;
  logic [15:0] exp_pc = RST_PC;
  logic [15:0] exp_req = RST_PC;
  bit          fault_exp = 1'b0;
  bit          fault_pend = 1'b0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hBEEF, a ^ 16'h1234};
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Memory: in-order responses, one per accepted request, lat cycles after acceptance
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n === 1'b1 && memq.size() > 0 && memq[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(memq[0].addr);
        memq.delete(0);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
      end
    end
  end

  // Scoreboard: the delivered stream must be sequential from the last reset/redirect target
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      exp_pc     = RST_PC;
      exp_req    = RST_PC;
      fault_exp  = 1'b0;
      fault_pend = 1'b0;
      first_req  = -1;
      first_ins  = -1;
      memq.delete();
      req_log.delete();
      ipc_log.delete();
      icode_log.delete();
    end else begin
      if (fault_pend) fault_exp = 1'b1;
      chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, fault_exp});
      if (fault_exp) begin
        chk("fault_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("fault_instr_valid", {31'd0, instr_valid}, 32'd0);
      end else if (redirect_valid) begin
        chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("redir_instr_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) fault_pend = 1'b1;
        exp_pc  = redirect_pc;
        exp_req = redirect_pc;
`else
        exp_pc  = {redirect_pc[15:2], 2'b00};
        exp_req = {redirect_pc[15:2], 2'b00};
`endif
      end else begin
        if (imem_req_valid) begin
          chk("req_addr", {16'd0, imem_req_addr}, {16'd0, exp_req});
          chk("req_budget", {31'd0, memq.size() < 2}, 32'd1);
          if (imem_req_ready) begin
            req_log.push_back({16'd0, imem_req_addr});
            if (first_req < 0) first_req = cyc;
            exp_req = exp_req + 16'd4;
          end
        end
        if (instr_valid) begin
          chk("instr_pc", {16'd0, instr_pc}, {16'd0, exp_pc});
          chk("instr_code", instr_code, mem_word(exp_pc));
          if (first_ins < 0) first_ins = cyc;
          if (instr_ready) begin
            ipc_log.push_back({16'd0, instr_pc});
            icode_log.push_back(instr_code);
            exp_pc = exp_pc + 16'd4;
          end
        end
      end
      if (imem_req_valid && imem_req_ready) memq.push_back('{imem_req_addr, cyc + lat});
    end
  end

  task automatic do_reset(input logic rdy);
    @(posedge clk); #1;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    instr_ready    = rdy;
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr_code", instr_code, 32'd0);
    chk("rst_instr_pc", {16'd0, instr_pc}, 32'd0);
    chk("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_two_outstanding();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (memq.size() == 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("two_outstanding_reached", {31'd0, ok}, 32'd1);
  endtask

  task automatic pulse_redirect(input logic [15:0] target, output int rmark, output int imark);
    @(posedge clk); #1;
    rmark          = req_log.size();
    imark          = ipc_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    int rm;
    int im;
    bit got;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    instr_ready    = 1'b0;

    // Basic stream, 1-cycle memory
    lat = 1;
    do_reset(1'b1);
    repeat (20) @(posedge clk);
    chk("req0", qget(req_log, 0), 32'h0000);
    chk("req1", qget(req_log, 1), 32'h0004);
    chk("req2", qget(req_log, 2), 32'h0008);
    chk("ipc0", qget(ipc_log, 0), 32'h0000);
    chk("ipc1", qget(ipc_log, 1), 32'h0004);
    chk("ipc2", qget(ipc_log, 2), 32'h0008);
    chk("code0", qget(icode_log, 0), 32'hBEEF_1234);
    chk("code1", qget(icode_log, 1), 32'hBEEB_1230);
    chk("code2", qget(icode_log, 2), 32'hBEE7_123C);
    chk("latency_l1", first_ins - first_req, 32'd2);
    @(posedge clk); #1 imem_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 imem_req_ready = 1'b1;
    repeat (10) @(posedge clk);

    // 3-cycle memory: two requests in flight, latency = memory + 1
    lat = 3;
    do_reset(1'b1);
    repeat (30) @(posedge clk);
    chk("latency_l3", first_ins - first_req, 32'd4);
    chk("l3_req1", qget(req_log, 1), 32'h0004);

    // Downstream stalled: buffer fills, exactly two requests
    lat = 1;
    do_reset(1'b0);
    repeat (12) @(posedge clk);
    chk("stall_req_count", req_log.size(), 32'd2);
    @(negedge clk);
    chk("stall_instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(posedge clk); #1 instr_ready = 1'b1;
    @(posedge clk); #1 instr_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      if (req_log.size() >= 3) begin
        got = 1'b1;
        break;
      end
    end
    chk("req_after_pop", {31'd0, got}, 32'd1);
    chk("req_after_pop_addr", qget(req_log, 2), 32'h0008);
    #1 instr_ready = 1'b1;
    repeat (10) @(posedge clk);

    // Redirect with two requests outstanding: both responses dropped
    lat = 3;
    do_reset(1'b1);
    wait_two_outstanding();
    pulse_redirect(16'h0100, rm, im);
    repeat (25) @(posedge clk);
    chk("redir_req", qget(req_log, rm), 32'h0100);
    chk("redir_ipc0", qget(ipc_log, im), 32'h0100);
    chk("redir_ipc1", qget(ipc_log, im + 1), 32'h0104);
    chk("redir_code0", qget(icode_log, im), 32'hBFEF_1334);

    // Redirect in the cycle a response arrives: that response is not stale-counted
    do_reset(1'b1);
    wait_two_outstanding();
    pulse_redirect(16'h0200, rm, im);
    repeat (25) @(posedge clk);
    chk("redir_resp_ipc0", qget(ipc_log, im), 32'h0200);
    chk("redir_resp_ipc1", qget(ipc_log, im + 1), 32'h0204);

    // PC wrap at the top of the address space
    lat = 1;
    do_reset(1'b1);
    repeat (5) @(posedge clk);
    pulse_redirect(16'hFFF8, rm, im);
    repeat (15) @(posedge clk);
    chk("wrap_req0", qget(req_log, rm), 32'hFFF8);
    chk("wrap_req1", qget(req_log, rm + 1), 32'hFFFC);
    chk("wrap_req2", qget(req_log, rm + 2), 32'h0000);
    chk("wrap_ipc2", qget(ipc_log, im + 2), 32'h0000);
    chk("wrap_code1", qget(icode_log, im + 1), 32'h4113_EDC8);

    // Misaligned redirect target
    do_reset(1'b1);
    repeat (5) @(posedge clk);
    pulse_redirect(16'h0102, rm, im);
`ifdef FETCH_ALIGN_CHECK_EN
    @(negedge clk);
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    repeat (10) @(negedge clk);
    chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    chk("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("fault_no_instr", {31'd0, instr_valid}, 32'd0);
    chk("fault_req_count", req_log.size(), rm);
`else
    repeat (10) @(posedge clk);
    chk("align_req", qget(req_log, rm), 32'h0100);
    chk("align_ipc", qget(ipc_log, im), 32'h0100);
    @(negedge clk);
    chk("align_no_fault", {31'd0, fetch_fault}, 32'd0);
`endif

    // Reset with two requests outstanding, then restart from the reset PC
    lat = 3;
    do_reset(1'b1);
    wait_two_outstanding();
    do_reset(1'b1);
    repeat (20) @(posedge clk);
    chk("post_rst_req0", qget(req_log, 0), 32'h0000);
    chk("post_rst_ipc0", qget(ipc_log, 0), 32'h0000);
    chk("post_rst_ipc1", qget(ipc_log, 1), 32'h0004);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "timeout");
  end

endmodule
